reg_bank: RTL and testbench

- Four-entry, 8-bit general register bank for the CPU datapath.
- Sits directly upstream of the 4:1 and 2:1 operand-select muxes. Its four raw register taps drive the mux data inputs.
- It also provides two registered read ports, with same-cycle write bypass, for the ALU operand latches.
- Supports one write and one increment/decrement per cycle, so a register can serve as a pointer or loop counter.

---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/reg_cell.sv | 51 +++++
 rtl/reg_bank.sv | 71 +++++++
 tb/tb_reg_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared widths and step-operation encodings for the four-entry register bank.
package reg_bank_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_SEL_W = 2;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_INC  = 2'b01;
    localparam logic [1:0] STEP_DEC  = 2'b10;

endpackage

// File: rtl/reg_cell.sv
// One bank register: write beats step, wrap/borrow carry and zero detect.
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             step_hit,
    input  logic [1:0]       step_op,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value,
    output logic             carry_next,
    output logic             zero
);

    // A colliding write suppresses the step entirely, carry included.
    always_comb begin
        next_value = value;
        carry_next = 1'b0;
        if (wr_hit) begin
            next_value = wr_data;
        end else if (step_hit) begin
            case (step_op)
                STEP_INC: begin
                    next_value = value + WIDTH'(1);
                    carry_next = &value;
                end
                STEP_DEC: begin
                    next_value = value - WIDTH'(1);
                    carry_next = ~|value;
                end
                STEP_NONE: next_value = value;
                default:   next_value = value;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= next_value;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/reg_bank.sv
// Four-entry register bank with raw taps, bypassed registered read ports and a step unit.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrEn,
    input  logic [1:0]           wrSel,
    input  logic [DATA_W-1:0]    wrData,
    input  logic [1:0]           stepOp,
    input  logic [1:0]           stepSel,
    input  logic [1:0]           rdSelA,
    input  logic [1:0]           rdSelB,
    output logic [DATA_W-1:0]    rdDataA,
    output logic [DATA_W-1:0]    rdDataB,
    output logic [DATA_W-1:0]    regTap0,
    output logic [DATA_W-1:0]    regTap1,
    output logic [DATA_W-1:0]    regTap2,
    output logic [DATA_W-1:0]    regTap3,
    output logic [NUM_REGS-1:0]  zeroFlag,
    output logic                 stepCarry
);

    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] step_hit;
    logic [NUM_REGS-1:0] carry_next;
    logic [DATA_W-1:0]   cur_value  [NUM_REGS];
    logic [DATA_W-1:0]   next_value [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign wr_hit[i]   = wrEn && (wrSel == REG_SEL_W'(i));
        assign step_hit[i] = (stepSel == REG_SEL_W'(i));

        reg_cell #(
            .WIDTH(DATA_W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .wr_hit     (wr_hit[i]),
            .wr_data    (wrData),
            .step_hit   (step_hit[i]),
            .step_op    (stepOp),
            .value      (cur_value[i]),
            .next_value (next_value[i]),
            .carry_next (carry_next[i]),
            .zero       (zeroFlag[i])
        );
    end

    // Reading next-state values gives same-cycle write/step bypass for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdDataA   <= '0;
            rdDataB   <= '0;
            stepCarry <= 1'b0;
        end else begin
            rdDataA   <= next_value[rdSelA];
            rdDataB   <= next_value[rdSelB];
            stepCarry <= |carry_next;
        end
    end

    assign regTap0 = cur_value[0];
    assign regTap1 = cur_value[1];
    assign regTap2 = cur_value[2];
    assign regTap3 = cur_value[3];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: directed scenarios then random traffic against an array model.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrEn = 1'b0;
    logic [1:0] wrSel = '0;
    logic [7:0] wrData = '0;
    logic [1:0] stepOp = '0;
    logic [1:0] stepSel = '0;
    logic [1:0] rdSelA = '0;
    logic [1:0] rdSelB = '0;
    logic [7:0] rdDataA, rdDataB;
    logic [7:0] regTap0, regTap1, regTap2, regTap3;
    logic [3:0] zeroFlag;
    logic       stepCarry;

    typedef struct packed {
        logic [3:0][7:0] regs;
        logic [7:0]      rd_a;
        logic [7:0]      rd_b;
        logic            carry;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_regs [4];
    int         n_vectors = 0;
    int         n_miscompares = 0;

    always #5 clk = ~clk;

    reg_bank #(
        .DATA_W   (8),
        .NUM_REGS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (wrEn),
        .wrSel     (wrSel),
        .wrData    (wrData),
        .stepOp    (stepOp),
        .stepSel   (stepSel),
        .rdSelA    (rdSelA),
        .rdSelB    (rdSelB),
        .rdDataA   (rdDataA),
        .rdDataB   (rdDataB),
        .regTap0   (regTap0),
        .regTap1   (regTap1),
        .regTap2   (regTap2),
        .regTap3   (regTap3),
        .zeroFlag  (zeroFlag),
        .stepCarry (stepCarry)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and record what the bank must show after that edge.
    task automatic applyStimulus(input logic r, input logic we, input logic [1:0] ws,
                                 input logic [7:0] wd, input logic [1:0] op,
                                 input logic [1:0] ss, input logic [1:0] ra, input logic [1:0] rb);
        exp_t       e;
        logic [7:0] nxt [4];
        logic       cy;
        @(negedge clk);
        rst = r; wrEn = we; wrSel = ws; wrData = wd;
        stepOp = op; stepSel = ss; rdSelA = ra; rdSelB = rb;
        for (int k = 0; k < 4; k++) nxt[k] = model_regs[k];
        cy = 1'b0;
        if (r) begin
            for (int k = 0; k < 4; k++) nxt[k] = 8'h00;
        end else begin
            if ((op == 2'd1 || op == 2'd2) && !(we && ws == ss)) begin
                if (op == 2'd1) begin
                    cy = (model_regs[ss] == 8'hFF);
                    nxt[ss] = 8'((int'(model_regs[ss]) + 1) % 256);
                end else begin
                    cy = (model_regs[ss] == 8'h00);
                    nxt[ss] = 8'((int'(model_regs[ss]) + 255) % 256);
                end
            end
            if (we) nxt[ws] = wd;
        end
        for (int k = 0; k < 4; k++) begin
            model_regs[k] = nxt[k];
            e.regs[k] = nxt[k];
        end
        e.rd_a  = nxt[ra];
        e.rd_b  = nxt[rb];
        e.carry = cy;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every settled cycle with a pending expectation is compared field by field.
    initial begin
        exp_t       e;
        logic [3:0] zf;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vectors++;
                for (int k = 0; k < 4; k++) zf[k] = (e.regs[k] == 8'h00);
                checkOutput("regTap0", regTap0, e.regs[0]);
                checkOutput("regTap1", regTap1, e.regs[1]);
                checkOutput("regTap2", regTap2, e.regs[2]);
                checkOutput("regTap3", regTap3, e.regs[3]);
                checkOutput("zeroFlag", {4'b0, zeroFlag}, {4'b0, zf});
                checkOutput("rdDataA", rdDataA, e.rd_a);
                checkOutput("rdDataB", rdDataB, e.rd_b);
                checkOutput("stepCarry", {7'b0, stepCarry}, {7'b0, e.carry});
            end
        end
    end

    initial begin
        int         waited;
        logic [7:0] wd;
        for (int k = 0; k < 4; k++) model_regs[k] = 8'h00;

        // reset then idle
        applyStimulus(1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 2'b00, 0, 0, 1);
        // write with same-cycle read bypass
        applyStimulus(0, 1, 2, 8'h5A, 2'b00, 0, 2, 3);
        applyStimulus(0, 0, 0, 8'h00, 2'b00, 0, 2, 2);
        // increment wrap and the following plain increment
        applyStimulus(0, 1, 1, 8'hFF, 2'b00, 0, 1, 0);
        applyStimulus(0, 0, 0, 8'h00, 2'b01, 1, 1, 2);
        applyStimulus(0, 0, 0, 8'h00, 2'b01, 1, 1, 1);
        // write/step collision, then disjoint write and decrement
        applyStimulus(0, 1, 3, 8'h10, 2'b00, 0, 3, 0);
        applyStimulus(0, 1, 3, 8'h80, 2'b01, 3, 3, 3);
        applyStimulus(0, 1, 0, 8'h33, 2'b10, 3, 0, 3);
        // decrement borrow, both ports on one register
        applyStimulus(0, 1, 0, 8'h00, 2'b00, 0, 1, 2);
        applyStimulus(0, 0, 0, 8'h00, 2'b10, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 2'b11, 2, 0, 0);
        // reset overrides a concurrent write
        applyStimulus(0, 1, 0, 8'h11, 2'b00, 0, 0, 1);
        applyStimulus(0, 1, 1, 8'h22, 2'b00, 0, 1, 2);
        applyStimulus(0, 1, 2, 8'h33, 2'b00, 0, 2, 3);
        applyStimulus(0, 1, 3, 8'h44, 2'b01, 0, 3, 0);
        applyStimulus(1, 1, 2, 8'hAB, 2'b01, 1, 2, 1);
        applyStimulus(0, 0, 0, 8'h00, 2'b00, 0, 0, 3);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       wd = 8'h00;
                1:       wd = 8'hFF;
                default: wd = 8'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom), wd,
                          2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (sb.size() > 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
